// File: rtl/fir_polyphase_interp.sv
// Polyphase interpolating FIR: each accepted sample yields INTERP_FACTOR scaled, saturated outputs.
// Optional macro FIR_INTERP_ROUND_EN selects round-half-up before the shift (default truncates).
module fir_polyphase_interp #(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS        = 8,
  parameter int INTERP_FACTOR   = 2,
  parameter int OUT_SHIFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic signed [DATA_WIDTH-1:0]        in,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic signed [DATA_WIDTH-1:0]        out,
  output logic                                out_valid,
  input  logic                                out_ready,
  input  logic [TAP_COEFF_WIDTH*NUM_TAPS-1:0] tap_coeffs
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the source holds data and valid until that edge, and out/out_valid hold while unconsumed.
  localparam int PHASE_TAPS = NUM_TAPS / INTERP_FACTOR;
  localparam int PH_W       = $clog2(INTERP_FACTOR);
  localparam int ACC_W      = DATA_WIDTH + TAP_COEFF_WIDTH + $clog2(PHASE_TAPS);
  localparam int SW         = ACC_W + 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DATA_WIDTH - 1)));
  localparam logic [PH_W-1:0]      LAST_PH = PH_W'(INTERP_FACTOR - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [PH_W-1:0]              phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0] x_q [PHASE_TAPS];
  logic signed [DATA_WIDTH-1:0] x_d [PHASE_TAPS];
  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic                         out_valid_q, out_valid_d;

  // Coefficients regrouped per branch: branch p uses h[k*L+p] against x[k].
  logic signed [TAP_COEFF_WIDTH-1:0] coef_ph [INTERP_FACTOR][PHASE_TAPS];
  for (genvar p = 0; p < INTERP_FACTOR; p++) begin : g_ph
    for (genvar k = 0; k < PHASE_TAPS; k++) begin : g_tap
      assign coef_ph[p][k] =
        tap_coeffs[TAP_COEFF_WIDTH*(k*INTERP_FACTOR+p) +: TAP_COEFF_WIDTH];
    end
  end

  logic signed [ACC_W-1:0]      acc;
  logic signed [SW-1:0]         acc_x;
  logic signed [SW-1:0]         scaled;
  logic signed [DATA_WIDTH-1:0] sat;

  always_comb begin
    acc = '0;
    for (int k = 0; k < PHASE_TAPS; k++) begin
      acc = acc + ACC_W'(coef_ph[phase_q][k]) * ACC_W'(x_q[k]);
    end
    acc_x = SW'(acc);
`ifdef FIR_INTERP_ROUND_EN
    scaled = (acc_x + SW'((2 ** OUT_SHIFT) / 2)) >>> OUT_SHIFT;
`else
    scaled = acc_x >>> OUT_SHIFT;
`endif
    if (scaled > SAT_MAX) begin
      sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat = scaled[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    x_d         = x_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    in_ready    = (state_q == IDLE);
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d[0] = in;
          for (int k = 1; k < PHASE_TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          phase_d = '0;
          state_d = RUN;
        end
      end
      default: begin
        // A consume and a load in the same cycle keep out_valid high.
        if (!out_valid_q || out_ready) begin
          out_d       = sat;
          out_valid_d = 1'b1;
          if (phase_q == LAST_PH) begin
            phase_d = '0;
            state_d = IDLE;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < PHASE_TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
